// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, legal oversampling ratios and parity selectors.
package uart_pkg;

   typedef logic [2:0] rx_state_t;

   localparam rx_state_t ST_IDLE   = 3'd0;
   localparam rx_state_t ST_START  = 3'd1;
   localparam rx_state_t ST_DATA   = 3'd2;
   localparam rx_state_t ST_PARITY = 3'd3;
   localparam rx_state_t ST_STOP   = 3'd4;

   localparam logic [5:0] PRESCALE_8  = 6'd8;
   localparam logic [5:0] PRESCALE_16 = 6'd16;
   localparam logic [5:0] PRESCALE_32 = 6'd32;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   // Anything other than 16 or 32 falls back to the slowest-safe ratio of 8.
   function automatic logic [5:0] legal_prescale(input logic [5:0] p);
      logic [5:0] r;
      r = PRESCALE_8;
      if (p == PRESCALE_16) r = PRESCALE_16;
      if (p == PRESCALE_32) r = PRESCALE_32;
      return r;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with 3-sample majority vote; strobes the decided bit and the end of each bit period.
module uart_rx_sampler
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       line,
   input  logic [5:0] prescale,
   output logic       bit_val,
   output logic       decide,
   output logic       bit_end
);

   logic [5:0] edge_cnt;
   logic [1:0] hist;
   logic [5:0] half;
   logic [5:0] last_edge;

   assign half      = {1'b0, prescale[5:1]};
   assign last_edge = prescale - 6'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_cnt <= '0;
         hist     <= 2'b11;
      end else begin
         hist <= {hist[0], line};
         if (!run || bit_end)
            edge_cnt <= '0;
         else
            edge_cnt <= edge_cnt + 6'd1;
      end
   end

   // Decision registers at the edge entering count P/2+1, voting on the
   // line as seen over the three preceding cycles.
   assign decide  = run && (edge_cnt == half);
   assign bit_end = run && (edge_cnt == last_edge);
   assign bit_val = (hist[1] & hist[0]) | (hist[1] & line) | (hist[0] & line);

endmodule

// File: rtl/uart_rx_top.sv
// Oversampling UART receiver: start/data/parity/stop framing, parity and stop checks,
// parallel word out with a one-cycle valid pulse.
module uart_rx_top
   import uart_pkg::*;
#(
   parameter int RX_Data_Width = 8
) (
   input  logic                     RX_CLK,
   input  logic                     RX_RST,
   input  logic                     RX_IN,
   input  logic [5:0]               RX_Prescale,
   input  logic                     RX_Parity_Enable,
   input  logic                     RX_Parity_Type,
   output logic [RX_Data_Width-1:0] RX_P_Data,
   output logic                     RX_Data_Valid,
   output logic                     RX_Parity_Error,
   output logic                     RX_Stop_Error
);

   localparam int BW = (RX_Data_Width > 1) ? $clog2(RX_Data_Width) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(RX_Data_Width - 1);

   rx_state_t               state;
   logic [5:0]              cfg_prescale;
   logic                    cfg_pe;
   logic                    cfg_ptype;
   logic [BW-1:0]           bit_cnt;
   logic [RX_Data_Width-1:0] shreg;
   logic                    frame_bad;
   logic                    run;
   logic                    bit_val;
   logic                    decide;
   logic                    bit_end;
   logic                    exp_parity;

   assign run        = (state != ST_IDLE);
   assign exp_parity = (^shreg) ^ (cfg_ptype == PARITY_ODD);

   uart_rx_sampler u_sampler (
      .clk      (RX_CLK),
      .rst      (RX_RST),
      .run      (run),
      .line     (RX_IN),
      .prescale (cfg_prescale),
      .bit_val  (bit_val),
      .decide   (decide),
      .bit_end  (bit_end)
   );

   always_ff @(posedge RX_CLK or posedge RX_RST) begin
      if (RX_RST) begin
         state           <= ST_IDLE;
         cfg_prescale    <= PRESCALE_8;
         cfg_pe          <= 1'b0;
         cfg_ptype       <= PARITY_EVEN;
         bit_cnt         <= '0;
         shreg           <= '0;
         frame_bad       <= 1'b0;
         RX_P_Data       <= '0;
         RX_Data_Valid   <= 1'b0;
         RX_Parity_Error <= 1'b0;
         RX_Stop_Error   <= 1'b0;
      end else begin
         RX_Data_Valid   <= 1'b0;
         RX_Parity_Error <= 1'b0;
         RX_Stop_Error   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!RX_IN) begin
                  state        <= ST_START;
                  cfg_prescale <= legal_prescale(RX_Prescale);
                  cfg_pe       <= RX_Parity_Enable;
                  cfg_ptype    <= RX_Parity_Type;
                  bit_cnt      <= '0;
                  frame_bad    <= 1'b0;
               end
            end
            ST_START: begin
               if (decide && bit_val)
                  state <= ST_IDLE;
               else if (bit_end)
                  state <= ST_DATA;
            end
            ST_DATA: begin
               if (decide)
                  shreg <= {bit_val, shreg[RX_Data_Width-1:1]};
               if (bit_end) begin
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     state   <= cfg_pe ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (decide && (bit_val != exp_parity)) begin
                  RX_Parity_Error <= 1'b1;
                  frame_bad       <= 1'b1;
               end
               if (bit_end)
                  state <= ST_STOP;
            end
            ST_STOP: begin
               // Leave at the decision point so a back-to-back start edge is not missed.
               if (decide) begin
                  state <= ST_IDLE;
                  if (!bit_val) begin
                     RX_Stop_Error <= 1'b1;
                  end else if (!frame_bad) begin
                     RX_P_Data     <= shreg;
                     RX_Data_Valid <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top: vector table, hand-built corner sequences and random frames.
module tb_uart_rx_top;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_in;
   logic [5:0] prescale;
   logic       pe;
   logic       ptype;
   logic [7:0] p_data;
   logic       dvalid;
   logic       perr;
   logic       serr;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_valid  = 0;
   int n_perr   = 0;
   int n_serr   = 0;
   int last_valid_cyc = -1;
   logic [7:0] vq[$];

   uart_rx_top #(.RX_Data_Width(8)) dut (
      .RX_CLK           (clk),
      .RX_RST           (rst),
      .RX_IN            (rx_in),
      .RX_Prescale      (prescale),
      .RX_Parity_Enable (pe),
      .RX_Parity_Type   (ptype),
      .RX_P_Data        (p_data),
      .RX_Data_Valid    (dvalid),
      .RX_Parity_Error  (perr),
      .RX_Stop_Error    (serr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (dvalid) begin
         n_valid        <= n_valid + 1;
         last_valid_cyc <= cyc;
         vq.push_back(p_data);
      end
      if (perr) n_perr <= n_perr + 1;
      if (serr) n_serr <= n_serr + 1;
   end

   typedef struct {
      logic [5:0] psc;
      logic       pen;
      logic       pty;
      logic [7:0] d;
      logic       flip;
      logic       stopb;
      int         ev;
      int         epe;
      int         ese;
      logic [7:0] ed;
   } vec_t;

   vec_t tbl[7];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int eff_p(input logic [5:0] p);
      return (p == 6'd16) ? 16 : (p == 6'd32) ? 32 : 8;
   endfunction

   task automatic drive_bit(input logic b, input int n);
      rx_in = b;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Frame as seen on the wire; jit moves each internal bit boundary by up to +/-jit cycles.
   task automatic send_frame(input logic [7:0] d, input logic pen, input logic pty,
                             input logic flip, input logic stopb, input int p, input int jit);
      logic bits[$];
      int off_prev;
      int off;
      bits = {};
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (pen) bits.push_back((^d) ^ pty ^ flip);
      bits.push_back(stopb);
      off_prev = 0;
      for (int i = 0; i < bits.size(); i++) begin
         if (jit > 0 && i < bits.size() - 1) off = int'($urandom_range(2 * jit)) - jit;
         else off = 0;
         drive_bit(bits[i], p + off - off_prev);
         off_prev = off;
      end
      rx_in = 1'b1;
   endtask

   task automatic run_frame(input string name, input logic [5:0] psc, input logic pen,
                            input logic pty, input logic [7:0] d, input logic flip,
                            input logic stopb, input int jit, input int ev, input int epe,
                            input int ese, input logic [7:0] ed);
      int v0, p0, s0, p;
      prescale = psc;
      pe       = pen;
      ptype    = pty;
      p  = eff_p(psc);
      v0 = n_valid;
      p0 = n_perr;
      s0 = n_serr;
      send_frame(d, pen, pty, flip, stopb, p, jit);
      idle(3 * p);
      check({name, "_valid"}, n_valid - v0, ev);
      check({name, "_perr"}, n_perr - p0, epe);
      check({name, "_serr"}, n_serr - s0, ese);
      check({name, "_data"}, int'(p_data), int'(ed));
   endtask

   initial begin
      int c, v0, p0, s0, qb;
      logic [7:0] model_data;

      tbl[0] = '{6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
      tbl[1] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1, 0, 0, 8'h3C};
      tbl[2] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 0, 1, 0, 8'h3C};
      tbl[3] = '{6'd32, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 0, 0, 1, 8'h3C};
      tbl[4] = '{6'd32, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 1, 0, 0, 8'h5A};
      tbl[5] = '{6'd32, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 0, 1, 1, 8'h5A};
      tbl[6] = '{6'd5,  1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 1, 0, 0, 8'h12};

      rst = 1'b1; rx_in = 1'b1; prescale = 6'd8; pe = 1'b0; ptype = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_data", int'(p_data), 0);
      check("rst_valid", int'(dvalid), 0);
      check("rst_perr", int'(perr), 0);
      check("rst_serr", int'(serr), 0);
      rst = 1'b0;
      idle(4);

      // First-valid latency: W=8, P=8, no parity -> D + 78
      c  = cyc;
      v0 = n_valid;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8, 0);
      idle(16);
      check("lat_count", n_valid - v0, 1);
      check("lat_cycle", last_valid_cyc, c + 78);
      check("lat_data", int'(p_data), 8'hA5);

      for (int i = 0; i < 7; i++)
         run_frame($sformatf("vec%0d", i), tbl[i].psc, tbl[i].pen, tbl[i].pty, tbl[i].d,
                   tbl[i].flip, tbl[i].stopb, 0, tbl[i].ev, tbl[i].epe, tbl[i].ese, tbl[i].ed);

      // Two-cycle glitch on the idle line is rejected silently
      prescale = 6'd16; pe = 1'b0;
      v0 = n_valid; p0 = n_perr; s0 = n_serr;
      drive_bit(1'b0, 2);
      idle(48);
      check("glitch_valid", n_valid - v0, 0);
      check("glitch_perr", n_perr - p0, 0);
      check("glitch_serr", n_serr - s0, 0);
      run_frame("after_glitch", 6'd16, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 0, 1, 0, 0, 8'h81);

      // Back-to-back frames, clean and then with per-bit skew
      for (int j = 0; j < 3; j++) begin
         prescale = 6'd8; pe = 1'b0;
         qb = vq.size();
         send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 8, (j == 0) ? 0 : 2);
         send_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 8, (j == 0) ? 0 : 2);
         idle(24);
         check($sformatf("b2b%0d_count", j), vq.size() - qb, 2);
         if (vq.size() - qb == 2) begin
            check($sformatf("b2b%0d_first", j), int'(vq[qb]), 8'h01);
            check($sformatf("b2b%0d_second", j), int'(vq[qb + 1]), 8'hFE);
         end
      end

      // Reset asserted mid-way through data bit 4 aborts the frame
      prescale = 6'd8; pe = 1'b0;
      v0 = n_valid; p0 = n_perr; s0 = n_serr;
      drive_bit(1'b0, 8);
      drive_bit(1'b1, 8);
      drive_bit(1'b0, 8);
      drive_bit(1'b1, 8);
      drive_bit(1'b0, 8);
      drive_bit(1'b1, 4);
      rst = 1'b1;
      #1;
      check("midrst_data", int'(p_data), 0);
      check("midrst_valid", int'(dvalid), 0);
      check("midrst_perr", int'(perr), 0);
      check("midrst_serr", int'(serr), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(48);
      check("midrst_no_valid", n_valid - v0, 0);
      check("midrst_no_err", (n_perr - p0) + (n_serr - s0), 0);
      check("midrst_data_held", int'(p_data), 0);
      run_frame("after_rst", 6'd8, 1'b0, 1'b0, 8'h6D, 1'b0, 1'b1, 0, 1, 0, 0, 8'h6D);
      model_data = 8'h6D;

      // Random frames against the framing rules
      for (int k = 0; k < 24; k++) begin
         int sel, ev, epe, ese;
         logic [5:0] ps;
         logic [7:0] d;
         logic pen, pty, flip, stopb;
         sel   = int'($urandom_range(3));
         ps    = (sel == 0) ? 6'd8 : (sel == 1) ? 6'd16 : (sel == 2) ? 6'd32 : 6'($urandom_range(63));
         d     = 8'($urandom_range(255));
         pen   = 1'($urandom_range(1));
         pty   = 1'($urandom_range(1));
         flip  = ($urandom_range(3) == 0);
         stopb = ($urandom_range(4) != 0);
         epe   = (pen && flip) ? 1 : 0;
         ese   = stopb ? 0 : 1;
         ev    = (epe == 0 && ese == 0) ? 1 : 0;
         if (ev == 1) model_data = d;
         run_frame($sformatf("rand%0d", k), ps, pen, pty, d, flip, stopb, 2, ev, epe, ese, model_data);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_top.md
# uart_rx_top

Oversampling UART receiver, the counterpart of the team's UART transmitter top. It samples the asynchronous serial line with a clock running at Prescale × bit rate and recovers frames of one start bit (0), RX_Data_Width data bits (LSB first), an optional parity bit and one stop bit (1). Each good frame is presented as a parallel word with a one-cycle valid pulse; parity and stop errors are flagged. It sits at the line-side input of the UART, opposite the transmitter.

## Interface
- RX_Data_Width, 8: data bits per frame.
- RX_CLK  in  1  oversampling clock, Prescale × bit rate. Single clock domain.
- RX_RST  in  1  reset, asynchronous, active-high.
- RX_IN  in  1  serial line; idle high. Treated as already synchronised.
- RX_Prescale  in  6  oversampling ratio; legal values 8, 16, 32; any other value is treated as 8.
- RX_Parity_Enable  in  1  1 = frame carries a parity bit.
- RX_Parity_Type  in  1  0 = even, 1 = odd.
- RX_P_Data  out  RX_Data_Width  last good word; reset 0; changes only with RX_Data_Valid.
- RX_Data_Valid  out  1  one-cycle pulse per good frame; reset 0.
- RX_Parity_Error  out  1  one-cycle pulse; reset 0.
- RX_Stop_Error  out  1  one-cycle pulse; reset 0.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Reset → IDLE.
- P, PE and the parity type are latched in the cycle a start is detected. Input changes mid-frame are ignored.
- IDLE: RX_IN = 0 sampled → START, with edge_cnt = 0 on the next cycle.
- Every bit period spans edge_cnt 0..P-1. The sampled bit is the majority of RX_IN at edges P/2-1, P/2 and P/2+1. It is decided at edge P/2+1.
- START: if the decided bit is 1, it is a glitch: go to IDLE at once with no flags. Otherwise, at edge P-1 → DATA.
- DATA: the decided bit shifts into the shift register, MSB end, so after W bits the LSB-first order is restored. bit_cnt counts 0..W-1. At edge P-1 of bit W-1 → PARITY if PE, else STOP.
- PARITY: expected bit = XOR(data) for even, ~XOR(data) for odd. On mismatch, pulse RX_Parity_Error at the decision and mark the frame bad. At edge P-1 → STOP.
- STOP: at the decision point, go to IDLE on the next cycle, without waiting for edge P-1; this leaves margin for resync.
  - Decided bit 0: pulse RX_Stop_Error; no valid pulse.
  - Decided bit 1 and frame not bad: load RX_P_Data and pulse RX_Data_Valid.
- Parity and stop errors may both occur in one frame. Each then pulses at its own decision point.
- Back-to-back frames: a start bit seen in the first IDLE cycle after STOP is accepted.

## Timing
- All outputs are registered. A pulse appears in the cycle after its decision edge.
- Let D be the cycle in which RX_IN = 0 is detected in IDLE. RX_Data_Valid is high in cycle D + 1 + (1+W+PE)·P + P/2 + 1.
- Example: W = 8, P = 8, PE = 0 gives D + 78.
- Asserting RX_RST at any point, including mid-frame, immediately forces:
  - state IDLE, all counters 0, shift register 0;
  - all outputs 0.
- The aborted frame produces no pulse.
- Bit decision falls at edge P/2+1 of each bit, giving ±(P/2-2) cycles of drift tolerance per frame.

## Structure
- Shared package (uart_pkg) holds:
  - state encoding (rx_state_t);
  - the prescale legal values;
  - a PARITY_EVEN/ODD constant shared with the transmitter.
- One sub-module, uart_rx_sampler: edge counter plus 3-sample majority. It outputs the sampled bit, a decide strobe and an end-of-bit strobe.
- The FSM, deserializer and parity/stop checks stay in the top.

## Test plan
- W = 8, P = 8, PE = 0; send 0xA5 → RX_P_Data = 0xA5, RX_Data_Valid pulses at D + 78, no error flags.
- P = 16, PE = 1, even; send 0x3C with parity bit 0 → valid 0x3C. Repeat with parity bit 1 → RX_Parity_Error pulse, no valid, RX_P_Data still 0x3C.
- P = 32, odd parity; stop bit driven 0 → RX_Stop_Error pulse, no valid. Next frame 0x5A → valid 0x5A.
- 2-cycle low glitch on idle RX_IN at P = 16 → returns to IDLE, no pulses. A following 0x81 frame is received correctly.
- Two back-to-back frames 0x01, 0xFE at P = 8 with a 1-bit stop → two valid pulses in order. Also apply ±2 cycles of skew per bit → still correct.
- RX_RST pulsed during the DATA bit 4 of a frame → all outputs 0, no pulse for that frame. A clean frame afterwards is received.
